// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// Request/response bundle shared by the fetch port, the data port and the backing memory port.
// No storage and no latency: this file only declares wires.
// No flow control: each requester posts at most one request and waits for its resp pulse.
interface mem_port_arbiter_if;
    // fetch side
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    // data side
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    // backing memory side
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    // arbiter view
    modport slave (
        input  imem_addr, imem_rmask,
        output imem_rdata, imem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    // pipeline + memory model view
    modport master (
        output imem_addr, imem_rmask,
        input  imem_rdata, imem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares one memory port between fetch (read-only) and data (read/write); one transaction in flight.
// Latency: a winning request in IDLE issues the same cycle; mem_resp is forwarded combinationally.
// Backpressure: one pending slot per requester; a request hitting a full slot or its own in-flight op is dropped.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned    SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_e;

    state_e state_q, state_d;

    // pending slots
    logic        i_vld_q, i_vld_d;
    logic [31:0] i_addr_q, i_addr_d;
    logic [3:0]  i_rmask_q, i_rmask_d;
    logic        d_vld_q, d_vld_d;
    logic [31:0] d_addr_q, d_addr_d;
    logic [3:0]  d_rmask_q, d_rmask_d;
    logic [3:0]  d_wmask_q, d_wmask_d;
    logic [31:0] d_wdata_q, d_wdata_d;

    // starvation counter
    logic [SW-1:0] d_streak_q, d_streak_d;

    // values held on the memory port while a transaction is outstanding
    logic [31:0] iss_addr_q, iss_addr_d;
    logic [31:0] iss_wdata_q, iss_wdata_d;
    logic        iss_wr_q, iss_wr_d;

    // incoming request decode; a combined read+write is treated as a write
    logic       i_req, d_req;
    logic [3:0] d_in_rmask;

    assign i_req      = |bus.imem_rmask;
    assign d_req      = |(bus.dmem_rmask | bus.dmem_wmask);
    assign d_in_rmask = (|bus.dmem_wmask) ? 4'h0 : bus.dmem_rmask;

    // candidates: slot contents first, otherwise the same-cycle request (bypass)
    logic        i_cand, d_cand;
    logic [31:0] i_c_addr, d_c_addr, d_c_wdata;
    logic [3:0]  i_c_rmask, d_c_rmask, d_c_wmask;

    assign i_cand    = i_vld_q | i_req;
    assign d_cand    = d_vld_q | d_req;
    assign i_c_addr  = i_vld_q ? i_addr_q  : bus.imem_addr;
    assign i_c_rmask = i_vld_q ? i_rmask_q : bus.imem_rmask;
    assign d_c_addr  = d_vld_q ? d_addr_q  : bus.dmem_addr;
    assign d_c_rmask = d_vld_q ? d_rmask_q : d_in_rmask;
    assign d_c_wmask = d_vld_q ? d_wmask_q : bus.dmem_wmask;
    assign d_c_wdata = d_vld_q ? d_wdata_q : bus.dmem_wdata;

    // arbitration: dmem preferred until it has won MAX_D_STREAK times over a waiting fetch
    logic in_idle, streak_full, grant_i, grant_d, i_cap, d_cap;

    assign in_idle     = (state_q == IDLE);
    assign streak_full = (d_streak_q == STREAK_MAX);
    assign grant_d     = in_idle & d_cand & (~i_cand | ~streak_full);
    assign grant_i     = in_idle & i_cand & ~grant_d;

    // capture into an empty slot unless bypassed this cycle or the requester's own op is in flight
    assign i_cap = i_req & ~i_vld_q & (state_q != WAIT_I) & ~grant_i;
    assign d_cap = d_req & ~d_vld_q & (state_q != WAIT_D) & ~grant_d;

    // pending slot next-state: a grant frees the slot, a capture fills it
    always_comb begin
        i_vld_d   = i_vld_q;
        i_addr_d  = i_addr_q;
        i_rmask_d = i_rmask_q;
        d_vld_d   = d_vld_q;
        d_addr_d  = d_addr_q;
        d_rmask_d = d_rmask_q;
        d_wmask_d = d_wmask_q;
        d_wdata_d = d_wdata_q;
        if (grant_i) begin
            i_vld_d = 1'b0;
        end
        if (i_cap) begin
            i_vld_d   = 1'b1;
            i_addr_d  = bus.imem_addr;
            i_rmask_d = bus.imem_rmask;
        end
        if (grant_d) begin
            d_vld_d = 1'b0;
        end
        if (d_cap) begin
            d_vld_d   = 1'b1;
            d_addr_d  = bus.dmem_addr;
            d_rmask_d = d_in_rmask;
            d_wmask_d = bus.dmem_wmask;
            d_wdata_d = bus.dmem_wdata;
        end
    end

    // streak counts dmem wins over a waiting fetch; any fetch grant or absent fetch clears it
    always_comb begin
        d_streak_d = d_streak_q;
        if (in_idle) begin
            if (!i_cand || grant_i) begin
                d_streak_d = '0;
            end else if (grant_d && !streak_full) begin
                d_streak_d = d_streak_q + SW'(1);
            end
        end
    end

    // FSM next state and all port outputs; masks pulse only on the issue cycle
    always_comb begin
        state_d        = state_q;
        iss_addr_d     = iss_addr_q;
        iss_wdata_d    = iss_wdata_q;
        iss_wr_d       = iss_wr_q;
        bus.mem_addr   = iss_addr_q;
        bus.mem_wdata  = iss_wdata_q;
        bus.mem_rmask  = 4'h0;
        bus.mem_wmask  = 4'h0;
        bus.imem_resp  = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    bus.mem_addr  = d_c_addr;
                    bus.mem_wdata = d_c_wdata;
                    bus.mem_rmask = d_c_rmask;
                    bus.mem_wmask = d_c_wmask;
                    iss_addr_d    = d_c_addr;
                    iss_wdata_d   = d_c_wdata;
                    iss_wr_d      = |d_c_wmask;
                    state_d       = WAIT_D;
                end else if (grant_i) begin
                    bus.mem_addr  = i_c_addr;
                    bus.mem_wdata = 32'h0;
                    bus.mem_rmask = i_c_rmask;
                    iss_addr_d    = i_c_addr;
                    iss_wdata_d   = 32'h0;
                    iss_wr_d      = 1'b0;
                    state_d       = WAIT_I;
                end
            end
            WAIT_I: begin
                if (bus.mem_resp) begin
                    bus.imem_resp  = 1'b1;
                    bus.imem_rdata = bus.mem_rdata;
                    state_d        = IDLE;
                end
            end
            WAIT_D: begin
                if (bus.mem_resp) begin
                    bus.dmem_resp  = 1'b1;
                    bus.dmem_rdata = iss_wr_q ? 32'h0 : bus.mem_rdata;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and issued-transaction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            iss_addr_q  <= 32'h0;
            iss_wdata_q <= 32'h0;
            iss_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            iss_addr_q  <= iss_addr_d;
            iss_wdata_q <= iss_wdata_d;
            iss_wr_q    <= iss_wr_d;
        end
    end

    // pending slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_vld_q   <= 1'b0;
            i_addr_q  <= 32'h0;
            i_rmask_q <= 4'h0;
            d_vld_q   <= 1'b0;
            d_addr_q  <= 32'h0;
            d_rmask_q <= 4'h0;
            d_wmask_q <= 4'h0;
            d_wdata_q <= 32'h0;
        end else begin
            i_vld_q   <= i_vld_d;
            i_addr_q  <= i_addr_d;
            i_rmask_q <= i_rmask_d;
            d_vld_q   <= d_vld_d;
            d_addr_q  <= d_addr_d;
            d_rmask_q <= d_rmask_d;
            d_wmask_q <= d_wmask_d;
            d_wdata_q <= d_wdata_d;
        end
    end

    // starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_streak_q <= '0;
        end else begin
            d_streak_q <= d_streak_d;
        end
    end

endmodule
